elastic_pipe_reg: RTL and testbench

//  Parametrised multi-lane, multi-stage pipeline register with valid/ready flow control, flush and occupancy.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage.sv | 36 +++
 rtl/elastic_pipe_reg.sv | 86 ++++++++
 tb/tb_elastic_pipe_reg.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pixel pipeline register family: lane width default,
// a width helper for counters and the pixel lane index enum.
package pipe_pkg;

  localparam int LANE_W          = 8;
  localparam int NUM_PIXEL_LANES = 3;

  typedef enum logic [1:0] {
    LANE_R = 2'd0,
    LANE_G = 2'd1,
    LANE_B = 2'd2
  } lane_e;

  // $clog2 that never yields a zero-width vector (values 0..n-1 need at least one bit)
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit offset of a pixel lane inside a packed multi-lane bus
  function automatic int lane_lsb(input lane_e lane, input int lane_w);
    return int'(lane) * lane_w;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the elastic pipeline: a valid flag plus a data word,
// loaded from the previous stage whenever the downstream ready chain allows it.
module pipe_stage #(
  parameter int DATA_W     = 24,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= prev_valid;
    end
  end

  // Bubbles never overwrite data, so an emptied stage keeps showing its last word
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      if (RESET_DATA) begin
        data <= '0;
      end
    end else if (en && prev_valid) begin
      data <= prev_data;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Multi-lane, multi-stage pipeline register with valid/ready flow control,
// synchronous flush and a registered occupancy count.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = LANE_W,
  parameter int CHANNELS   = NUM_PIXEL_LANES,
  parameter int DEPTH      = 2,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [WIDTH*CHANNELS-1:0]         data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [WIDTH*CHANNELS-1:0]         data_o,
  output logic [clog2_safe(DEPTH+1)-1:0]    occupancy_o
);

  localparam int BUS_W = WIDTH * CHANNELS;
  localparam int OCC_W = clog2_safe(DEPTH + 1);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_en;
  logic [BUS_W-1:0] stage_data [DEPTH];
  logic             xfer_in;
  logic             xfer_out;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      // A stage may advance when downstream accepts or any later stage is empty;
      // written flat rather than as a recursive chain to keep it loop-free
      assign stage_en[k] = ready_i | ~(&stage_valid[DEPTH-1:k]);

      if (k == 0) begin : g_first
        pipe_stage #(
          .DATA_W     (BUS_W),
          .RESET_DATA (RESET_DATA)
        ) u_stage (
          .clk_i      (clk_i),
          .rst_i      (rst_i),
          .clear_i    (clear_i),
          .en         (stage_en[k]),
          .prev_valid (valid_i),
          .prev_data  (data_i),
          .valid      (stage_valid[k]),
          .data       (stage_data[k])
        );
      end else begin : g_next
        pipe_stage #(
          .DATA_W     (BUS_W),
          .RESET_DATA (RESET_DATA)
        ) u_stage (
          .clk_i      (clk_i),
          .rst_i      (rst_i),
          .clear_i    (clear_i),
          .en         (stage_en[k]),
          .prev_valid (stage_valid[k-1]),
          .prev_data  (stage_data[k-1]),
          .valid      (stage_valid[k]),
          .data       (stage_data[k])
        );
      end
    end
  endgenerate

  // Refusing input during a flush keeps a word offered with clear_i from vanishing unseen
  assign ready_o  = stage_en[0] & ~clear_i;
  assign valid_o  = stage_valid[DEPTH-1];
  assign data_o   = stage_data[DEPTH-1];
  assign xfer_in  = valid_i & ready_o;
  assign xfer_out = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      occupancy_o <= '0;
    end else begin
      occupancy_o <= occupancy_o + OCC_W'(xfer_in) - OCC_W'(xfer_out);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios on the default configuration and
// randomized traffic on several depth/lane configurations against a queue model.
module tb_elastic_pipe_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;

  logic        vin0 = 1'b0, rdy0 = 1'b1, rdyo0, vout0;
  logic [23:0] din0 = '0, dout0;
  logic [1:0]  occ0;

  logic        vin1 = 1'b0, rdy1 = 1'b1, rdyo1, vout1;
  logic [7:0]  din1 = '0, dout1;
  logic [0:0]  occ1;

  logic        vin2 = 1'b0, rdy2 = 1'b1, rdyo2, vout2;
  logic [31:0] din2 = '0, dout2;
  logic [1:0]  occ2;

  logic        vin3 = 1'b0, rdy3 = 1'b1, rdyo3, vout3;
  logic [31:0] din3 = '0, dout3;
  logic [2:0]  occ3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(LANE_W), .CHANNELS(3), .DEPTH(2), .RESET_DATA(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(vin0), .ready_o(rdyo0),
    .data_i(din0), .valid_o(vout0), .ready_i(rdy0), .data_o(dout0), .occupancy_o(occ0));

  elastic_pipe_reg #(.WIDTH(8), .CHANNELS(1), .DEPTH(1), .RESET_DATA(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(vin1), .ready_o(rdyo1),
    .data_i(din1), .valid_o(vout1), .ready_i(rdy1), .data_o(dout1), .occupancy_o(occ1));

  elastic_pipe_reg #(.WIDTH(8), .CHANNELS(4), .DEPTH(3), .RESET_DATA(1'b1)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(vin2), .ready_o(rdyo2),
    .data_i(din2), .valid_o(vout2), .ready_i(rdy2), .data_o(dout2), .occupancy_o(occ2));

  elastic_pipe_reg #(.WIDTH(8), .CHANNELS(4), .DEPTH(4), .RESET_DATA(1'b0)) dut3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(vin3), .ready_o(rdyo3),
    .data_i(din3), .valid_o(vout3), .ready_i(rdy3), .data_o(dout3), .occupancy_o(occ3));

  task automatic drive(input int i, input logic v, input logic r, input logic [31:0] d);
    case (i)
      0: begin vin0 = v; rdy0 = r; din0 = d[23:0]; end
      1: begin vin1 = v; rdy1 = r; din1 = d[7:0]; end
      2: begin vin2 = v; rdy2 = r; din2 = d; end
      default: begin vin3 = v; rdy3 = r; din3 = d; end
    endcase
  endtask

  function automatic logic vout_of(input int i);
    case (i)
      0: return vout0;
      1: return vout1;
      2: return vout2;
      default: return vout3;
    endcase
  endfunction

  function automatic logic rdyo_of(input int i);
    case (i)
      0: return rdyo0;
      1: return rdyo1;
      2: return rdyo2;
      default: return rdyo3;
    endcase
  endfunction

  function automatic logic [31:0] dout_of(input int i);
    case (i)
      0: return {8'h00, dout0};
      1: return {24'h0, dout1};
      2: return dout2;
      default: return dout3;
    endcase
  endfunction

  function automatic int occ_of(input int i);
    case (i)
      0: return int'(occ0);
      1: return int'(occ1);
      2: return int'(occ2);
      default: return int'(occ3);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, $urandom);
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vout_of(i) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_valid inst%0d: got %b expected 0", i, vout_of(i));
      end
      checks++;
      if (occ_of(i) !== 0) begin
        errors++;
        $display("[TB] FAIL reset_occ inst%0d: got %0d expected 0", i, occ_of(i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout_of(i) !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_data inst%0d: got %h expected 0", i, dout_of(i));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b1, 32'h0);
    #1;
    checks++;
    if (rdyo0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", rdyo0);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    vin0 = 1'b1; din0 = 24'h112233; rdy0 = 1'b1;
    tick();
    checks++;
    if (vout0 !== 1'b0 || occ0 !== 2'd1) begin
      errors++;
      $display("[TB] FAIL latency_edge0: got valid=%b occ=%0d expected valid=0 occ=1", vout0, occ0);
    end
    @(negedge clk);
    vin0 = 1'b0;
    tick();
    checks++;
    if (vout0 !== 1'b1 || dout0 !== 24'h112233) begin
      errors++;
      $display("[TB] FAIL latency_out: got valid=%b data=%h expected valid=1 data=112233", vout0, dout0);
    end
    tick();
    checks++;
    if (vout0 !== 1'b0 || occ0 !== 2'd0) begin
      errors++;
      $display("[TB] FAIL latency_after: got valid=%b occ=%0d expected valid=0 occ=0", vout0, occ0);
    end
  endtask

  task automatic test_back_pressure();
    logic [23:0] got[$];
    logic pending;
    @(negedge clk);
    rdy0 = 1'b0; vin0 = 1'b1; din0 = 24'h000001;
    tick();
    @(negedge clk);
    din0 = 24'h000002;
    tick();
    @(negedge clk);
    din0 = 24'h000003;
    #1;
    checks++;
    if (rdyo0 !== 1'b0 || occ0 !== 2'd2) begin
      errors++;
      $display("[TB] FAIL bp_full: got ready=%b occ=%0d expected ready=0 occ=2", rdyo0, occ0);
    end
    checks++;
    if (vout0 !== 1'b1 || dout0 !== 24'h000001) begin
      errors++;
      $display("[TB] FAIL bp_head: got valid=%b data=%h expected valid=1 data=000001", vout0, dout0);
    end
    tick();
    checks++;
    if (vout0 !== 1'b1 || dout0 !== 24'h000001 || occ0 !== 2'd2) begin
      errors++;
      $display("[TB] FAIL bp_stall: got valid=%b data=%h occ=%0d expected 1/000001/2", vout0, dout0, occ0);
    end
    pending = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rdy0 = 1'b1;
      vin0 = pending;
      #1;
      if (vout0 && rdy0) got.push_back(dout0);
      if (vin0 && rdyo0) pending = 1'b0;
      @(posedge clk);
    end
    checks++;
    if (got.size() !== 3) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d words expected 3", got.size());
    end
    for (int j = 0; j < 3; j++) begin
      if (j < got.size()) begin
        checks++;
        if (got[j] !== 24'(j + 1)) begin
          errors++;
          $display("[TB] FAIL bp_order[%0d]: got %h expected %h", j, got[j], 24'(j + 1));
        end
      end
    end
  endtask

  task automatic test_streaming();
    logic [23:0] sent[$];
    logic [23:0] got[$];
    @(negedge clk);
    vin0 = 1'b0; rdy0 = 1'b1;
    tick();
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      if (c < 100) begin
        vin0 = 1'b1;
        din0 = 24'($urandom);
      end else begin
        vin0 = 1'b0;
      end
      #1;
      if (vin0 && rdyo0) sent.push_back(din0);
      if (vout0 && rdy0) got.push_back(dout0);
      if (c >= 2 && c < 100) begin
        checks++;
        if (occ0 !== 2'd2 || vout0 !== 1'b1 || rdyo0 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stream_steady c=%0d: got occ=%0d valid=%b ready=%b expected 2/1/1", c, occ0, vout0, rdyo0);
        end
      end
      @(posedge clk);
    end
    checks++;
    if (sent.size() !== 100 || got.size() !== 100) begin
      errors++;
      $display("[TB] FAIL stream_count: got sent=%0d out=%0d expected 100/100", sent.size(), got.size());
    end
    for (int j = 0; j < 100; j++) begin
      if (j < sent.size() && j < got.size()) begin
        checks++;
        if (got[j] !== sent[j]) begin
          errors++;
          $display("[TB] FAIL stream_word[%0d]: got %h expected %h", j, got[j], sent[j]);
        end
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    rdy0 = 1'b0; vin0 = 1'b1; din0 = 24'h0000A1;
    tick();
    @(negedge clk);
    din0 = 24'h0000A2;
    tick();
    @(negedge clk);
    clear = 1'b1; vin0 = 1'b1; din0 = 24'hDEAD00;
    #1;
    checks++;
    if (rdyo0 !== 1'b0 || vout0 !== 1'b1 || occ0 !== 2'd2) begin
      errors++;
      $display("[TB] FAIL flush_cycle: got ready=%b valid=%b occ=%0d expected 0/1/2", rdyo0, vout0, occ0);
    end
    tick();
    checks++;
    if (vout0 !== 1'b0 || occ0 !== 2'd0 || dout0 !== 24'h0) begin
      errors++;
      $display("[TB] FAIL flush_after: got valid=%b occ=%0d data=%h expected 0/0/000000", vout0, occ0, dout0);
    end
    @(negedge clk);
    clear = 1'b0; vin0 = 1'b0; rdy0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (vout0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_no_output c=%0d: got valid=%b data=%h expected valid=0", c, vout0, dout0);
      end
    end
  endtask

  task automatic test_random(input int cycles);
    int          dep[4] = '{2, 1, 3, 4};
    bit          rdz[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] msk[4] = '{32'h00FFFFFF, 32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] qd[4][$];
    int          qp[4][$];
    logic [31:0] last_d[4];
    bit          known[4];
    logic        v[4], r[4], exp_rdy, exp_v;
    logic [31:0] d[4];
    logic        prev_hold[4];
    logic [31:0] prev_data[4];
    int          pct, p, np;

    @(negedge clk);
    rst = 1'b1; clear = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qd[i].delete();
      qp[i].delete();
      last_d[i] = 32'h0;
      known[i] = rdz[i];
      prev_hold[i] = 1'b0;
      prev_data[i] = 32'h0;
    end

    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      clear = ($urandom_range(0, 39) == 0);
      pct = ((c / 250) % 2 == 1) ? 35 : 75;
      for (int i = 0; i < 4; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        r[i] = ($urandom_range(0, 99) < pct);
        d[i] = $urandom & msk[i];
        drive(i, v[i], r[i], d[i]);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        logic [31:0] nd[$];
        int          npos[$];
        exp_rdy = (r[i] || qd[i].size() < dep[i]) && !clear;
        checks++;
        if (rdyo_of(i) !== exp_rdy) begin
          errors++;
          $display("[TB] FAIL rnd_ready inst%0d c=%0d: got %b expected %b", i, c, rdyo_of(i), exp_rdy);
        end
        if (prev_hold[i]) begin
          checks++;
          if (vout_of(i) !== 1'b1 || dout_of(i) !== prev_data[i]) begin
            errors++;
            $display("[TB] FAIL rnd_stable inst%0d c=%0d: got valid=%b data=%h expected 1/%h", i, c, vout_of(i), dout_of(i), prev_data[i]);
          end
        end
        prev_hold[i] = vout_of(i) && !r[i] && !clear;
        prev_data[i] = dout_of(i);

        if (clear) begin
          qd[i].delete();
          qp[i].delete();
          if (rdz[i]) begin
            last_d[i] = 32'h0;
            known[i] = 1'b1;
          end
        end else begin
          for (int j = 0; j < qd[i].size(); j++) begin
            p = qp[i][j];
            if (p == dep[i] - 1) begin
              if (!r[i]) begin
                nd.push_back(qd[i][j]);
                npos.push_back(p);
              end
            end else begin
              np = (r[i] || j < dep[i] - 1 - p) ? p + 1 : p;
              if (np == dep[i] - 1 && np != p) begin
                last_d[i] = qd[i][j];
                known[i] = 1'b1;
              end
              nd.push_back(qd[i][j]);
              npos.push_back(np);
            end
          end
          if (v[i] && exp_rdy) begin
            nd.push_back(d[i]);
            npos.push_back(0);
            if (dep[i] == 1) begin
              last_d[i] = d[i];
              known[i] = 1'b1;
            end
          end
          qd[i] = nd;
          qp[i] = npos;
        end
      end

      tick();
      for (int i = 0; i < 4; i++) begin
        exp_v = (qd[i].size() > 0) && (qp[i][0] == dep[i] - 1);
        checks++;
        if (vout_of(i) !== exp_v || occ_of(i) !== qd[i].size()) begin
          errors++;
          $display("[TB] FAIL rnd_state inst%0d c=%0d: got valid=%b occ=%0d expected valid=%b occ=%0d", i, c, vout_of(i), occ_of(i), exp_v, qd[i].size());
        end
        if (known[i]) begin
          checks++;
          if (dout_of(i) !== last_d[i]) begin
            errors++;
            $display("[TB] FAIL rnd_data inst%0d c=%0d: got %h expected %h", i, c, dout_of(i), last_d[i]);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_pressure();
    test_streaming();
    test_flush();
    test_random(2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
